// File: rtl/ysyx_22040729_lsu_ctrl_if.sv
// Bundle of the request, response and memory-port signals of the LSU controller.
// The master modport is the controller's view: it consumes requests, produces
// responses and drives the memory data port. The slave modport is the
// environment's view (CPU stage plus memory).
interface ysyx_22040729_lsu_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [63:0]       req_wdata;

    logic              resp_valid;
    logic              resp_ready;
    logic [63:0]       resp_rdata;
    logic              resp_err;

    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_wdata;
    logic [63:0]       mem_rdata;

    modport master (
        input  req_valid, req_wen, req_addr, req_size, req_signed, req_wdata,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_wen, mem_addr, mem_wdata
    );

    modport slave (
        output req_valid, req_wen, req_addr, req_size, req_signed, req_wdata,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_wen, mem_addr, mem_wdata
    );
endinterface

// File: rtl/ysyx_22040729_lsu_ctrl.sv
// Load/store controller for a byte-addressed memory with a 1-cycle synchronous
// read and an 8-byte-wide write port. Loads are a single read; stores are a
// read-modify-write so that bytes above the access size are written back as-is.
// Optional feature: define YSYX_22040729_LSU_MISALIGN_CHK_EN to reject requests
// whose address is not a multiple of the access size (resp_err=1, no memory
// access). Without it resp_err is tied low.
module ysyx_22040729_lsu_ctrl #(
    parameter int ADDR_W = 16
) (
    input logic                      clk,
    input logic                      rst,
    ysyx_22040729_lsu_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LD,
        S_WR,
        S_RESP
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_req_ready;
    logic              w_mem_wen;
    logic              w_resp_valid;
    logic              w_accept;
    logic              w_misalign;

    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic              r_signed;
    logic              r_wen;
    logic [63:0]       r_wdata;
    logic [63:0]       r_rdata;
    logic [63:0]       r_mem_wdata;

    logic [63:0]       w_mask;
    logic [63:0]       w_merge;
    logic [63:0]       w_load_ext;

    assign w_accept = (r_state == S_IDLE) && bus.req_valid;

`ifdef YSYX_22040729_LSU_MISALIGN_CHK_EN
    logic r_err;

    // Misaligned when any address bit below the access size is set.
    always_comb begin
        case (bus.req_size)
            2'd0:    w_misalign = 1'b0;
            2'd1:    w_misalign = bus.req_addr[0];
            2'd2:    w_misalign = |bus.req_addr[1:0];
            default: w_misalign = |bus.req_addr[2:0];
        endcase
    end

    // Error flag is latched at accept and held through RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= w_misalign;
        end
    end

    assign bus.resp_err = r_err;
`else
    assign w_misalign   = 1'b0;
    assign bus.resp_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential logic uses non-blocking assignments so every register
        // samples pre-edge values and updates together.
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        // NOTE: each signal is given a default first so no path leaves it
        // unassigned and no latch is inferred.
        w_next       = r_state;
        w_req_ready  = 1'b0;
        w_mem_wen    = 1'b0;
        w_resp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid) begin
                    w_next = w_misalign ? S_RESP : S_RD;
                end
            end
            S_RD:   w_next = r_wen ? S_WR : S_LD;
            S_LD:   w_next = S_RESP;
            S_WR: begin
                w_mem_wen = 1'b1;
                w_next    = S_RESP;
            end
            S_RESP: begin
                w_resp_valid = 1'b1;
                if (bus.resp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Byte-lane mask, store merge and load extension for the registered size.
    always_comb begin
        case (r_size)
            2'd0:    w_mask = 64'h0000_0000_0000_00FF;
            2'd1:    w_mask = 64'h0000_0000_0000_FFFF;
            2'd2:    w_mask = 64'h0000_0000_FFFF_FFFF;
            default: w_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        w_merge = (bus.mem_rdata & ~w_mask) | (r_wdata & w_mask);
        case (r_size)
            2'd0:    w_load_ext = {{56{r_signed & bus.mem_rdata[7]}},  bus.mem_rdata[7:0]};
            2'd1:    w_load_ext = {{48{r_signed & bus.mem_rdata[15]}}, bus.mem_rdata[15:0]};
            2'd2:    w_load_ext = {{32{r_signed & bus.mem_rdata[31]}}, bus.mem_rdata[31:0]};
            default: w_load_ext = bus.mem_rdata;
        endcase
    end

    // Request capture, load result and last written memory word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= '0;
            r_size      <= 2'd0;
            r_signed    <= 1'b0;
            r_wen       <= 1'b0;
            r_wdata     <= 64'd0;
            r_rdata     <= 64'd0;
            r_mem_wdata <= 64'd0;
        end else begin
            if (w_accept) begin
                r_addr   <= bus.req_addr;
                r_size   <= bus.req_size;
                r_signed <= bus.req_signed;
                r_wen    <= bus.req_wen;
                r_wdata  <= bus.req_wdata;
                r_rdata  <= 64'd0;
            end
            if (r_state == S_LD) begin
                r_rdata <= w_load_ext;
            end
            if (r_state == S_WR) begin
                r_rdata     <= 64'd0;
                r_mem_wdata <= w_merge;
            end
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.resp_valid = w_resp_valid;
    assign bus.resp_rdata = r_rdata;
    assign bus.mem_wen    = w_mem_wen;
    assign bus.mem_addr   = r_addr;
    // The merged word is presented combinationally during WR and held afterwards.
    assign bus.mem_wdata  = (r_state == S_WR) ? w_merge : r_mem_wdata;
endmodule

// File: tb/tb_ysyx_22040729_lsu_ctrl.sv
// Directed bench for ysyx_22040729_lsu_ctrl with a byte-addressed memory model
// and a response scoreboard.
module tb_ysyx_22040729_lsu_ctrl;
    localparam int ADDR_W = 16;

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } resp_t;

    logic  clk = 1'b0;
    logic  rst;
    int    checks = 0;
    int    failures = 0;
    int    wen_count = 0;
    bit    preload_done = 1'b0;
    resp_t sb_q[$];
    logic [7:0] mem [0:65535];

    ysyx_22040729_lsu_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    ysyx_22040729_lsu_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Memory: 1-cycle synchronous read, 8-byte write, addresses wrap.
    always @(posedge clk) begin
        logic [63:0] rd;
        if (!preload_done) begin
            for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
            mem[16'h10] <= 8'h11; mem[16'h11] <= 8'h22;
            mem[16'h12] <= 8'h33; mem[16'h13] <= 8'h44;
            mem[16'h14] <= 8'h55; mem[16'h15] <= 8'h66;
            mem[16'h16] <= 8'h77; mem[16'h17] <= 8'h88;
            preload_done <= 1'b1;
            bus.mem_rdata <= 64'd0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                logic [15:0] a;
                a = bus.mem_addr + 16'(i);
                rd[8*i +: 8] = mem[a];
                if (bus.mem_wen === 1'b1) mem[a] <= bus.mem_wdata[8*i +: 8];
            end
            bus.mem_rdata <= rd;
        end
    end

    always @(negedge clk) begin
        if (bus.mem_wen === 1'b1) wen_count++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%016h expected=0x%016h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input string tag, input logic wen, input logic [15:0] addr,
                          input logic [1:0] size, input logic sgn, input logic [63:0] wdata,
                          input resp_t exp, input int exp_lat, input logic [63:0] exp_mwdata,
                          input int hold);
        int    lat;
        int    n;
        int    wen_before;
        int    wen_at;
        int    exp_wen_at;
        resp_t e;
        sb_q.push_back(exp);
        exp_wen_at = (wen && exp_lat == 3) ? 2 : -1;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " req_ready"}, 64'(bus.req_ready), 64'd1);
        wen_before     = wen_count;
        wen_at         = -1;
        bus.req_valid  = 1'b1;
        bus.req_wen    = wen;
        bus.req_addr   = addr;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_wdata  = wdata;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        while (bus.resp_valid !== 1'b1 && lat < 20) begin
            if (lat == 1) check({tag, " mem_addr"}, 64'(bus.mem_addr), 64'(addr));
            if (bus.mem_wen === 1'b1) begin
                wen_at = lat;
                check({tag, " mem_wdata"}, bus.mem_wdata, exp_mwdata);
            end
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        check({tag, " resp_rdata"}, bus.resp_rdata, e.rdata);
        check({tag, " resp_err"}, 64'(bus.resp_err), 64'(e.err));
        check({tag, " wen_cycle"}, 64'(wen_at), 64'(exp_wen_at));
        if (hold > 0) begin
            bus.req_valid = 1'b1;
            bus.req_wen   = 1'b0;
            bus.req_addr  = 16'h0000;
            bus.req_size  = 2'd0;
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                check({tag, " hold resp_valid"}, 64'(bus.resp_valid), 64'd1);
                check({tag, " hold resp_rdata"}, bus.resp_rdata, e.rdata);
                check({tag, " hold req_ready"}, 64'(bus.req_ready), 64'd0);
            end
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b0;
        check({tag, " idle req_ready"}, 64'(bus.req_ready), 64'd1);
        check({tag, " idle resp_valid"}, 64'(bus.resp_valid), 64'd0);
        check({tag, " wen_count"}, 64'(wen_count - wen_before), (exp_wen_at == 2) ? 64'd1 : 64'd0);
    endtask

    initial begin
        int wen_before;
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_wen    = 1'b0;
        bus.req_addr   = '0;
        bus.req_size   = 2'd0;
        bus.req_signed = 1'b0;
        bus.req_wdata  = 64'd0;
        bus.resp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst req_ready", 64'(bus.req_ready), 64'd1);
        check("rst resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst resp_rdata", bus.resp_rdata, 64'd0);
        check("rst resp_err", 64'(bus.resp_err), 64'd0);
        check("rst mem_wen", 64'(bus.mem_wen), 64'd0);
        check("rst mem_addr", 64'(bus.mem_addr), 64'd0);
        check("rst mem_wdata", bus.mem_wdata, 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Unaligned word load on the fresh preload.
`ifdef YSYX_22040729_LSU_MISALIGN_CHK_EN
        do_req("lw_0x12", 1'b0, 16'h0012, 2'd2, 1'b0, 64'd0, '{64'd0, 1'b1}, 1, 64'd0, 0);
`else
        do_req("lw_0x12", 1'b0, 16'h0012, 2'd2, 1'b0, 64'd0, '{64'h0000_0000_6655_4433, 1'b0}, 3, 64'd0, 0);
`endif
        do_req("lb_0x17", 1'b0, 16'h0017, 2'd0, 1'b1, 64'd0, '{64'hFFFF_FFFF_FFFF_FF88, 1'b0}, 3, 64'd0, 0);
        do_req("lbu_0x17", 1'b0, 16'h0017, 2'd0, 1'b0, 64'd0, '{64'h0000_0000_0000_0088, 1'b0}, 3, 64'd0, 0);
        do_req("sh_0x10", 1'b1, 16'h0010, 2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_BEEF,
               '{64'd0, 1'b0}, 3, 64'h8877_6655_4433_BEEF, 0);
        do_req("ld_0x10", 1'b0, 16'h0010, 2'd3, 1'b0, 64'd0, '{64'h8877_6655_4433_BEEF, 1'b0}, 3, 64'd0, 0);
        do_req("sb_0x13", 1'b1, 16'h0013, 2'd0, 1'b0, 64'h1234_5678_9ABC_DEAA,
               '{64'd0, 1'b0}, 3, 64'h0000_0088_7766_55AA, 0);
        do_req("lwu_0x14", 1'b0, 16'h0014, 2'd2, 1'b0, 64'd0, '{64'h0000_0000_8877_6655, 1'b0}, 3, 64'd0, 0);
        do_req("lwu_0x10", 1'b0, 16'h0010, 2'd2, 1'b0, 64'd0, '{64'h0000_0000_AA33_BEEF, 1'b0}, 3, 64'd0, 0);
        do_req("lw_0x10", 1'b0, 16'h0010, 2'd2, 1'b1, 64'd0, '{64'hFFFF_FFFF_AA33_BEEF, 1'b0}, 3, 64'd0, 0);
        do_req("lh_0x10", 1'b0, 16'h0010, 2'd1, 1'b1, 64'd0, '{64'hFFFF_FFFF_FFFF_BEEF, 1'b0}, 3, 64'd0, 0);
        do_req("lhu_hold", 1'b0, 16'h0010, 2'd1, 1'b0, 64'd0, '{64'h0000_0000_0000_BEEF, 1'b0}, 3, 64'd0, 5);

        // Reset asserted during the RD cycle of a double store.
        wen_before     = wen_count;
        bus.req_valid  = 1'b1;
        bus.req_wen    = 1'b1;
        bus.req_addr   = 16'h0010;
        bus.req_size   = 2'd3;
        bus.req_wdata  = 64'hDEAD_BEEF_DEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("rd mem_wen", 64'(bus.mem_wen), 64'd0);
        rst = 1'b1;
        #1;
        check("arst req_ready", 64'(bus.req_ready), 64'd1);
        check("arst resp_valid", 64'(bus.resp_valid), 64'd0);
        check("arst resp_rdata", bus.resp_rdata, 64'd0);
        check("arst resp_err", 64'(bus.resp_err), 64'd0);
        check("arst mem_wen", 64'(bus.mem_wen), 64'd0);
        check("arst mem_addr", 64'(bus.mem_addr), 64'd0);
        check("arst mem_wdata", bus.mem_wdata, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("arst wen_count", 64'(wen_count - wen_before), 64'd0);
        do_req("ld_after_rst", 1'b0, 16'h0010, 2'd3, 1'b0, 64'd0, '{64'h8877_6655_AA33_BEEF, 1'b0}, 3, 64'd0, 0);

        // Top-of-address-space word store and double read back.
        do_req("sw_0xfffc", 1'b1, 16'hFFFC, 2'd2, 1'b0, 64'hFFFF_FFFF_CAFE_F00D,
               '{64'd0, 1'b0}, 3, 64'h0000_0000_CAFE_F00D, 0);
        do_req("ld_0xfff8", 1'b0, 16'hFFF8, 2'd3, 1'b0, 64'd0, '{64'hCAFE_F00D_0000_0000, 1'b0}, 3, 64'd0, 0);

        check("scoreboard empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ysyx_22040729_lsu_ctrl.md
Name: ysyx_22040729_lsu_ctrl

Overview:
Load/store initiator that drives the byte-addressed, 1-cycle synchronous-read unified memory data port (wen/addr/wdata/rdata). The memory write port always writes 8 consecutive bytes. This block therefore converts CPU byte/half/word/double loads and stores into single reads and read-modify-write sequences. It sits between the EXU/MEM stage and the memory. It has a valid/ready request channel and a valid/ready response channel.

Parameters:
ADDR_W, 16, byte-address width; equals $clog2(DATA_DEPTH) of the memory.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept (high only in IDLE)
req_wen  in  1  1=store, 0=load
req_addr  in  ADDR_W  byte address
req_size  in  2  0=byte, 1=half, 2=word, 3=double
req_signed  in  1  loads: sign-extend when 1, zero-extend when 0; ignored for stores
req_wdata  in  64  store data, right-aligned (low bytes used)
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_rdata  out  64  extended load data; 0 for stores
resp_err  out  1  misaligned access flag (see Optional Feature)
mem_wen  out  1  to memory wen
mem_addr  out  ADDR_W  to memory addr
mem_wdata  out  64  to memory wdata
mem_rdata  in  64  from memory rdata; valid the cycle after mem_addr is presented

Behaviour:
- States: IDLE, RD, LD, WR, RESP. Clock is clk. Reset is asynchronous, active-high on rst.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_wen=0, mem_addr=0, mem_wdata=0.
- mem_wen and req_ready are decoded from state only. An asserted rst therefore drops mem_wen immediately, including mid-store. A reset during RD or WR aborts with no partial write.
- IDLE: req_ready=1. On req_valid&&req_ready, register addr, size, signed, wen and wdata, then go to RD.
- mem_addr always equals the registered address. It holds its value outside RD/WR.
- RD (cycle 1): mem_wen=0. The memory samples rdata at the end of this cycle. Next state is WR if the request is a store, otherwise LD.
- LD (cycle 2): register resp_rdata from mem_rdata. Take the low 1/2/4/8 bytes and extend them per req_signed; a double is passed through unchanged. Next state is RESP.
- WR (cycle 2): mem_wen=1. mem_wdata is mem_rdata with its low 1/2/4/8 bytes replaced by the same bytes of the stored wdata; the upper bytes are written back unchanged. resp_rdata=0. Next state is RESP.
- RESP (cycle 3): resp_valid=1, and resp_rdata/resp_err are held stable. On resp_ready, go to IDLE.
- While resp_ready is low, the block stays in RESP with all outputs frozen. req_ready stays 0.
- There is no same-cycle accept from RESP; a new request can be accepted one cycle after the response handshake at the earliest.
- Latency from accept to resp_valid is 3 cycles. Minimum issue interval is 4 cycles.
- Address arithmetic wraps modulo 2^ADDR_W, matching the memory's addr+i. No range check is performed.
- mem_wdata holds its last value outside WR.

Optional Feature:
Macro YSYX_22040729_LSU_MISALIGN_CHK_EN.
- Defined: a request whose req_addr is not a multiple of (1<<req_size) is accepted, then goes IDLE->RESP directly. No mem_wen pulse occurs, resp_err=1 and resp_rdata=0. resp_err=0 for aligned requests.
- Undefined: no alignment check, and resp_err is tied to 0. Unaligned accesses complete normally through the byte-addressed memory.

Test Plan:
- Memory preload: bytes 0x10..0x17 = 11 22 33 44 55 66 77 88. Load byte, signed, at 0x17 -> resp_rdata=0xFFFFFFFFFFFFFF88 exactly 3 cycles after accept; unsigned -> 0x88.
- Store half 0xBEEF at 0x10, then load double at 0x10 -> 0x887766554433BEEF. Exactly one mem_wen cycle is observed, in WR.
- Store byte 0xAA at 0x13 -> bytes 0x14..0x1A unchanged; load word at 0x10 -> 0x00000000AA332211 (after the prior case, bytes 0x10..0x11 are EF BE) -> 0x00000000AA33BEEF.
- Hold resp_ready=0 for 5 cycles in RESP -> resp_valid stays 1, resp_rdata stable, req_ready=0, no new accept; release -> IDLE next cycle.
- Assert rst during the RD of a store -> mem_wen never rises, all outputs return to reset values, and the memory contents are unchanged.
- Load word at 0x12: with the macro defined -> resp_err=1, resp_rdata=0, no memory access. Without the macro -> resp_rdata=0x0000000066554433 (fresh preload), resp_err=0.
